// File: rtl/cursor_overlay_draw.sv
// Plus-shaped cursor drawing engine: restores the saved background at the old
// position, saves the background at the new position, then draws the cursor.
module cursor_overlay_draw #(
   parameter int unsigned FB_W = 64,
   parameter int unsigned FB_H = 64,
   parameter int unsigned PX_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [7:0]      in_x,
   input  logic [7:0]      in_y,
   input  logic [PX_W-1:0] cursor_color,
   input  logic            commit,
   input  logic [PX_W-1:0] commit_color,
   output logic [7:0]      fb_x,
   output logic [7:0]      fb_y,
   output logic [PX_W-1:0] fb_wdata,
   output logic            fb_we,
   output logic            fb_re,
   input  logic [PX_W-1:0] fb_rdata,
   output logic            busy,
   output logic            done
);

   localparam int unsigned NSLOT = 5;
   localparam logic signed [8:0] X_MAX = 9'(FB_W - 1);
   localparam logic signed [8:0] Y_MAX = 9'(FB_H - 1);

   typedef enum logic [2:0] {IDLE, RESTORE, READ, WRITE, DONE} state_t;

   typedef struct packed {
      logic       ok;
      logic [7:0] x;
      logic [7:0] y;
   } slot_t;

   // Position and clip status of shape slot k around centre (cx, cy).
   function automatic slot_t slot_at(input logic [7:0] cx, input logic [7:0] cy,
                                     input logic [2:0] k);
      logic signed [8:0] dx;
      logic signed [8:0] dy;
      logic signed [8:0] px;
      logic signed [8:0] py;
      slot_t s;
      dx = '0;
      dy = '0;
      case (k)
         3'd1:    dy = -9'sd1;
         3'd2:    dx = 9'sd1;
         3'd3:    dy = 9'sd1;
         3'd4:    dx = -9'sd1;
         default: ;
      endcase
      px = $signed({1'b0, cx}) + dx;
      py = $signed({1'b0, cy}) + dy;
      s.ok = (px >= 9'sd0) && (px <= X_MAX) && (py >= 9'sd0) && (py <= Y_MAX);
      s.x  = px[7:0];
      s.y  = py[7:0];
      return s;
   endfunction

   function automatic logic slot_ok(input logic [7:0] cx, input logic [7:0] cy,
                                    input logic [2:0] k);
      slot_t s;
      s = slot_at(cx, cy, k);
      return s.ok;
   endfunction

   state_t          state;
   logic [2:0]      idx;
   logic [2:0]      idx_inc;
   logic [2:0]      idx_dec;
   logic [7:0]      old_x;
   logic [7:0]      old_y;
   logic [7:0]      new_x;
   logic [7:0]      new_y;
   logic [PX_W-1:0] color;
   logic            saved_valid;
   logic [PX_W-1:0] save_data [NSLOT];
   logic [NSLOT-1:0] save_valid;

   slot_t           old_first;
   slot_t           old_next;
   slot_t           new_first;
   slot_t           new_next;
   slot_t           in_first;
   logic            new_cur_ok;
   logic [PX_W-1:0] save0_data;
   logic            save0_valid;

   assign idx_inc = idx + 3'd1;
   assign idx_dec = idx - 3'd1;

   // Slot geometry for the cycle being entered; a same-cycle commit overrides slot 0.
   always_comb begin
      old_first   = slot_at(old_x, old_y, 3'd0);
      old_next    = slot_at(old_x, old_y, idx_inc);
      new_first   = slot_at(new_x, new_y, 3'd0);
      new_next    = slot_at(new_x, new_y, idx_inc);
      in_first    = slot_at(in_x, in_y, 3'd0);
      new_cur_ok  = slot_ok(new_x, new_y, idx);
      save0_data  = commit ? commit_color : save_data[0];
      save0_valid = (commit ? 1'b1 : save_valid[0]) & old_first.ok;
   end

   // Sequencer; framebuffer strobes are registered alongside the state they belong to.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= '0;
         fb_x        <= '0;
         fb_y        <= '0;
         fb_wdata    <= '0;
         fb_we       <= 1'b0;
         fb_re       <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         saved_valid <= 1'b0;
         save_valid  <= '0;
         old_x       <= '0;
         old_y       <= '0;
         new_x       <= '0;
         new_y       <= '0;
         color       <= '0;
      end else begin
         fb_we <= 1'b0;
         fb_re <= 1'b0;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (commit && saved_valid) begin
                  save_data[0]  <= commit_color;
                  save_valid[0] <= old_first.ok;
               end
               if (start) begin
                  new_x <= in_x;
                  new_y <= in_y;
                  color <= cursor_color;
                  busy  <= 1'b1;
                  idx   <= '0;
                  if (saved_valid) begin
                     state    <= RESTORE;
                     fb_x     <= old_first.x;
                     fb_y     <= old_first.y;
                     fb_wdata <= save0_data;
                     fb_we    <= save0_valid;
                  end else begin
                     state <= READ;
                     fb_x  <= in_first.x;
                     fb_y  <= in_first.y;
                     fb_re <= in_first.ok;
                  end
               end
            end
            RESTORE: begin
               if (idx == 3'd4) begin
                  state <= READ;
                  idx   <= '0;
                  fb_x  <= new_first.x;
                  fb_y  <= new_first.y;
                  fb_re <= new_first.ok;
               end else begin
                  idx      <= idx_inc;
                  fb_x     <= old_next.x;
                  fb_y     <= old_next.y;
                  fb_wdata <= save_data[idx_inc];
                  fb_we    <= save_valid[idx_inc] & old_next.ok;
               end
            end
            READ: begin
               // Read data trails the strobe by one cycle; idx 5 only drains slot 4.
               if (idx != 3'd0) save_data[idx_dec] <= fb_rdata;
               if (idx < 3'd5) save_valid[idx] <= new_cur_ok;
               if (idx == 3'd5) begin
                  state    <= WRITE;
                  idx      <= '0;
                  fb_x     <= new_first.x;
                  fb_y     <= new_first.y;
                  fb_wdata <= color;
                  fb_we    <= new_first.ok;
               end else begin
                  idx   <= idx_inc;
                  fb_x  <= new_next.x;
                  fb_y  <= new_next.y;
                  fb_re <= new_next.ok && (idx_inc != 3'd5);
               end
            end
            WRITE: begin
               if (idx == 3'd4) begin
                  state       <= DONE;
                  idx         <= '0;
                  done        <= 1'b1;
                  old_x       <= new_x;
                  old_y       <= new_y;
                  saved_valid <= 1'b1;
               end else begin
                  idx      <= idx_inc;
                  fb_x     <= new_next.x;
                  fb_y     <= new_next.y;
                  fb_wdata <= color;
                  fb_we    <= new_next.ok;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cursor_overlay_draw.sv
// Directed bench for cursor_overlay_draw with a 64x64 framebuffer model and
// per-cycle access traces captured after each accepted start.
module tb_cursor_overlay_draw;

   localparam int MAXC = 24;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] in_x;
   logic [7:0] in_y;
   logic [7:0] cursor_color;
   logic       commit;
   logic [7:0] commit_color;
   logic [7:0] fb_x;
   logic [7:0] fb_y;
   logic [7:0] fb_wdata;
   logic       fb_we;
   logic       fb_re;
   logic [7:0] fb_rdata;
   logic       busy;
   logic       done;

   logic [7:0] mem [64][64];
   logic       preload = 1'b0;

   int tests = 0;
   int fails = 0;

   logic       tr_we   [MAXC+1];
   logic       tr_re   [MAXC+1];
   logic       tr_busy [MAXC+1];
   logic       tr_done [MAXC+1];
   logic [7:0] tr_x    [MAXC+1];
   logic [7:0] tr_y    [MAXC+1];
   logic [7:0] tr_wd   [MAXC+1];
   logic [7:0] tr_rd   [MAXC+1];
   int         done_cycle;
   int         done_count;

   int dxs [5] = '{0, 0, 1, 0, -1};
   int dys [5] = '{0, -1, 0, 1, 0};

   cursor_overlay_draw #(.FB_W(64), .FB_H(64), .PX_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .in_x         (in_x),
      .in_y         (in_y),
      .cursor_color (cursor_color),
      .commit       (commit),
      .commit_color (commit_color),
      .fb_x         (fb_x),
      .fb_y         (fb_y),
      .fb_wdata     (fb_wdata),
      .fb_we        (fb_we),
      .fb_re        (fb_re),
      .fb_rdata     (fb_rdata),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   // Framebuffer model: one-cycle read latency.
   always @(posedge clk) begin
      if (preload) begin
         for (int yy = 0; yy < 64; yy++)
            for (int xx = 0; xx < 64; xx++)
               mem[yy][xx] <= 8'h11;
      end else if (fb_we && fb_x < 8'd64 && fb_y < 8'd64) begin
         mem[fb_y[5:0]][fb_x[5:0]] <= fb_wdata;
      end
      if (fb_re && fb_x < 8'd64 && fb_y < 8'd64)
         fb_rdata <= mem[fb_y[5:0]][fb_x[5:0]];
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic fill_background();
      @(negedge clk);
      preload = 1'b1;
      @(negedge clk);
      preload = 1'b0;
   endtask

   // Issue a start and record MAXC cycles; optional start pulse / reset at given cycles.
   task automatic run_draw(input logic [7:0] x, input logic [7:0] y, input logic [7:0] col,
                           input int pulse_at, input int rst_at);
      @(negedge clk);
      start = 1'b1;
      in_x = x;
      in_y = y;
      cursor_color = col;
      @(posedge clk);
      done_cycle = 0;
      done_count = 0;
      for (int c = 1; c <= MAXC; c++) begin
         @(negedge clk);
         tr_we[c] = fb_we;
         tr_re[c] = fb_re;
         tr_busy[c] = busy;
         tr_done[c] = done;
         tr_x[c] = fb_x;
         tr_y[c] = fb_y;
         tr_wd[c] = fb_wdata;
         tr_rd[c] = fb_rdata;
         if (done) begin
            done_count++;
            if (done_cycle == 0) done_cycle = c;
         end
         if (c == 1) start = 1'b0;
         if (c == pulse_at) begin
            start = 1'b1;
            in_x = 8'd33;
            in_y = 8'd33;
         end
         if (c == pulse_at + 1) start = 1'b0;
         if (c == rst_at) rst = 1'b1;
         if (c == rst_at + 1) rst = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      commit = 1'b0;
      in_x = '0;
      in_y = '0;
      cursor_color = '0;
      commit_color = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests++;
      if ({busy, done, fb_we, fb_re} !== 4'b0000) begin
         fails++;
         $display("FAIL reset_ctrl: got %b required 0000", {busy, done, fb_we, fb_re});
      end
      tests++;
      if ({fb_x, fb_y, fb_wdata} !== 24'h0) begin
         fails++;
         $display("FAIL reset_bus: got %h required 000000", {fb_x, fb_y, fb_wdata});
      end
      rst = 1'b0;
      fill_background();
   endtask

   task automatic test_first_draw();
      logic [31:0] got, exp;
      run_draw(8'd10, 8'd10, 8'hFF, 0, 0);
      tests++;
      if (done_cycle != 12 || done_count != 1) begin
         fails++;
         $display("FAIL first_done: got cycle %0d count %0d required 12/1", done_cycle, done_count);
      end
      for (int k = 0; k < 5; k++) begin
         got = 32'({tr_re[1+k], tr_we[1+k], tr_x[1+k], tr_y[1+k]});
         exp = 32'({1'b1, 1'b0, 8'(10 + dxs[k]), 8'(10 + dys[k])});
         tests++;
         if (got !== exp) begin
            fails++;
            $display("FAIL first_read%0d: got %h required %h", k, got, exp);
         end
         got = 32'({tr_re[7+k], tr_we[7+k], tr_x[7+k], tr_y[7+k], tr_wd[7+k]});
         exp = 32'({1'b0, 1'b1, 8'(10 + dxs[k]), 8'(10 + dys[k]), 8'hFF});
         tests++;
         if (got !== exp) begin
            fails++;
            $display("FAIL first_write%0d: got %h required %h", k, got, exp);
         end
      end
      tests++;
      if ({tr_re[6], tr_we[6]} !== 2'b00) begin
         fails++;
         $display("FAIL first_drain: got %b required 00", {tr_re[6], tr_we[6]});
      end
      tests++;
      if ({tr_busy[12], tr_we[12], tr_re[12], tr_busy[13], tr_done[13]} !== 5'b10000) begin
         fails++;
         $display("FAIL first_tail: got %b required 10000",
                  {tr_busy[12], tr_we[12], tr_re[12], tr_busy[13], tr_done[13]});
      end
      for (int k = 0; k < 5; k++) begin
         tests++;
         if (mem[10 + dys[k]][10 + dxs[k]] !== 8'hFF) begin
            fails++;
            $display("FAIL first_mem%0d: got %h required ff", k, mem[10 + dys[k]][10 + dxs[k]]);
         end
      end
   endtask

   task automatic test_move();
      logic [31:0] got, exp;
      run_draw(8'd20, 8'd5, 8'hFF, 0, 0);
      tests++;
      if (done_cycle != 17 || done_count != 1) begin
         fails++;
         $display("FAIL move_done: got cycle %0d count %0d required 17/1", done_cycle, done_count);
      end
      for (int k = 0; k < 5; k++) begin
         got = 32'({tr_re[1+k], tr_we[1+k], tr_x[1+k], tr_y[1+k], tr_wd[1+k]});
         exp = 32'({1'b0, 1'b1, 8'(10 + dxs[k]), 8'(10 + dys[k]), 8'h11});
         tests++;
         if (got !== exp) begin
            fails++;
            $display("FAIL move_restore%0d: got %h required %h", k, got, exp);
         end
         got = 32'({tr_re[6+k], tr_we[6+k], tr_x[6+k], tr_y[6+k]});
         exp = 32'({1'b1, 1'b0, 8'(20 + dxs[k]), 8'(5 + dys[k])});
         tests++;
         if (got !== exp) begin
            fails++;
            $display("FAIL move_read%0d: got %h required %h", k, got, exp);
         end
         got = 32'({tr_re[12+k], tr_we[12+k], tr_x[12+k], tr_y[12+k], tr_wd[12+k]});
         exp = 32'({1'b0, 1'b1, 8'(20 + dxs[k]), 8'(5 + dys[k]), 8'hFF});
         tests++;
         if (got !== exp) begin
            fails++;
            $display("FAIL move_write%0d: got %h required %h", k, got, exp);
         end
         tests++;
         if (mem[10 + dys[k]][10 + dxs[k]] !== 8'h11) begin
            fails++;
            $display("FAIL move_clean%0d: got %h required 11", k, mem[10 + dys[k]][10 + dxs[k]]);
         end
      end
   endtask

   task automatic test_corner();
      logic [31:0] got, exp;
      logic ok [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      run_draw(8'd0, 8'd0, 8'hA5, 0, 0);
      tests++;
      if (done_cycle != 17) begin
         fails++;
         $display("FAIL corner_done: got cycle %0d required 17", done_cycle);
      end
      for (int k = 0; k < 5; k++) begin
         tests++;
         if ({tr_re[6+k], tr_we[6+k], tr_re[12+k], tr_we[12+k]} !== {ok[k], 1'b0, 1'b0, ok[k]}) begin
            fails++;
            $display("FAIL corner_strobe%0d: got %b required %b", k,
                     {tr_re[6+k], tr_we[6+k], tr_re[12+k], tr_we[12+k]}, {ok[k], 1'b0, 1'b0, ok[k]});
         end
         if (ok[k]) begin
            got = 32'({tr_x[12+k], tr_y[12+k], tr_wd[12+k]});
            exp = 32'({8'(dxs[k]), 8'(dys[k]), 8'hA5});
            tests++;
            if (got !== exp) begin
               fails++;
               $display("FAIL corner_write%0d: got %h required %h", k, got, exp);
            end
         end
      end
      run_draw(8'd40, 8'd40, 8'hFF, 0, 0);
      for (int k = 0; k < 5; k++) begin
         tests++;
         if (tr_we[1+k] !== ok[k]) begin
            fails++;
            $display("FAIL corner_restore_we%0d: got %b required %b", k, tr_we[1+k], ok[k]);
         end
         if (ok[k]) begin
            got = 32'({tr_x[1+k], tr_y[1+k], tr_wd[1+k]});
            exp = 32'({8'(dxs[k]), 8'(dys[k]), 8'h11});
            tests++;
            if (got !== exp) begin
               fails++;
               $display("FAIL corner_restore%0d: got %h required %h", k, got, exp);
            end
            tests++;
            if (mem[dys[k]][dxs[k]] !== 8'h11) begin
               fails++;
               $display("FAIL corner_mem%0d: got %h required 11", k, mem[dys[k]][dxs[k]]);
            end
         end
      end
   endtask

   task automatic test_commit();
      logic [31:0] got, exp;
      run_draw(8'd10, 8'd10, 8'hFF, 0, 0);
      @(negedge clk);
      commit = 1'b1;
      commit_color = 8'h3C;
      @(negedge clk);
      commit = 1'b0;
      run_draw(8'd30, 8'd30, 8'hFF, 0, 0);
      for (int k = 0; k < 5; k++) begin
         got = 32'({tr_we[1+k], tr_x[1+k], tr_y[1+k], tr_wd[1+k]});
         exp = 32'({1'b1, 8'(10 + dxs[k]), 8'(10 + dys[k]), (k == 0) ? 8'h3C : 8'h11});
         tests++;
         if (got !== exp) begin
            fails++;
            $display("FAIL commit_restore%0d: got %h required %h", k, got, exp);
         end
      end
      tests++;
      if (mem[10][10] !== 8'h3C) begin
         fails++;
         $display("FAIL commit_mem: got %h required 3c", mem[10][10]);
      end
   endtask

   task automatic test_adjacent();
      logic [31:0] got, exp;
      int n_ff;
      fill_background();
      run_draw(8'd10, 8'd10, 8'hFF, 0, 0);
      run_draw(8'd11, 8'd10, 8'hFF, 0, 0);
      for (int k = 0; k < 5; k++) begin
         got = 32'({tr_we[1+k], tr_x[1+k], tr_y[1+k], tr_wd[1+k]});
         exp = 32'({1'b1, 8'(10 + dxs[k]), 8'(10 + dys[k]), 8'h11});
         tests++;
         if (got !== exp) begin
            fails++;
            $display("FAIL adj_restore%0d: got %h required %h", k, got, exp);
         end
         got = 32'({tr_re[6+k], tr_x[6+k], tr_y[6+k], tr_rd[7+k]});
         exp = 32'({1'b1, 8'(11 + dxs[k]), 8'(10 + dys[k]), 8'h11});
         tests++;
         if (got !== exp) begin
            fails++;
            $display("FAIL adj_read%0d: got %h required %h", k, got, exp);
         end
      end
      n_ff = 0;
      for (int yy = 0; yy < 64; yy++)
         for (int xx = 0; xx < 64; xx++)
            if (mem[yy][xx] === 8'hFF) n_ff++;
      tests++;
      if (n_ff != 5 || mem[10][11] !== 8'hFF || mem[10][12] !== 8'hFF || mem[9][11] !== 8'hFF ||
          mem[11][11] !== 8'hFF || mem[10][10] !== 8'hFF) begin
         fails++;
         $display("FAIL adj_residue: got %0d cursor pixels required 5 on the (11,10) plus", n_ff);
      end
      run_draw(8'd50, 8'd50, 8'hFF, 0, 0);
      for (int k = 0; k < 5; k++) begin
         got = 32'({tr_we[1+k], tr_x[1+k], tr_y[1+k], tr_wd[1+k]});
         exp = 32'({1'b1, 8'(11 + dxs[k]), 8'(10 + dys[k]), 8'h11});
         tests++;
         if (got !== exp) begin
            fails++;
            $display("FAIL adj_saved%0d: got %h required %h", k, got, exp);
         end
      end
   endtask

   task automatic test_busy_reset();
      run_draw(8'd20, 8'd20, 8'hFF, 13, 0);
      tests++;
      if (done_cycle != 17 || done_count != 1 || tr_busy[MAXC] !== 1'b0) begin
         fails++;
         $display("FAIL busy_ignore: got cycle %0d count %0d busy %b required 17/1/0",
                  done_cycle, done_count, tr_busy[MAXC]);
      end
      run_draw(8'd25, 8'd25, 8'hFF, 0, 14);
      tests++;
      if ({tr_busy[15], tr_done[15], tr_we[15], tr_re[15]} !== 4'b0000) begin
         fails++;
         $display("FAIL rst_mid: got %b required 0000",
                  {tr_busy[15], tr_done[15], tr_we[15], tr_re[15]});
      end
      tests++;
      if (done_count != 0) begin
         fails++;
         $display("FAIL rst_nodone: got %0d done pulses required 0", done_count);
      end
      run_draw(8'd5, 8'd5, 8'h77, 0, 0);
      tests++;
      if (done_cycle != 12) begin
         fails++;
         $display("FAIL rst_first_done: got cycle %0d required 12", done_cycle);
      end
      tests++;
      if ({tr_re[1], tr_we[1], tr_x[1], tr_y[1]} !== {1'b1, 1'b0, 8'd5, 8'd5}) begin
         fails++;
         $display("FAIL rst_first_read: got %h required 20505",
                  {tr_re[1], tr_we[1], tr_x[1], tr_y[1]});
      end
   endtask

   initial begin
      test_reset();
      test_first_draw();
      test_move();
      test_corner();
      test_commit();
      test_adjacent();
      test_busy_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
